// File: rtl/caesar_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// caesar_ctrl_pkg
// Shared types and constants for the Caesar stream arbiter and its helpers.
//   state_e     : arbiter FSM states (IDLE, ISSUE, DRAIN)
//   key_t       : key/mode bundle latched for the duration of a burst
//   *_A / *_Z   : ASCII letter boundaries
//   KEY_NUM_MAX : largest legal shift amount
// -----------------------------------------------------------------------------
package caesar_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic       mode;
        logic       dir_1;
        logic       dir_3;
        logic [4:0] num_1;
        logic [4:0] num_3;
    } key_t;

    localparam logic [7:0] UPPERCASE_A = 8'h41;
    localparam logic [7:0] UPPERCASE_Z = 8'h5A;
    localparam logic [7:0] LOWERCASE_A = 8'h61;
    localparam logic [7:0] LOWERCASE_Z = 8'h7A;
    localparam int         KEY_NUM_MAX = 26;

endpackage

// File: rtl/caesar_rr_arb.sv
// -----------------------------------------------------------------------------
// caesar_rr_arb
// Two-way round-robin grant. The stream selected by rr_ptr_i is preferred;
// the other stream wins only when the preferred one has nothing to send.
// Ports:
//   valid_i  [1:0] in  : per-stream request
//   rr_ptr_i       in  : preferred stream id
//   gnt_o    [1:0] out : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module caesar_rr_arb
    import caesar_ctrl_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (rr_ptr_i) begin
            if (valid_i[1])      gnt_o = 2'b10;
            else if (valid_i[0]) gnt_o = 2'b01;
        end else begin
            if (valid_i[0])      gnt_o = 2'b01;
            else if (valid_i[1]) gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/caesar_stream_arbiter.sv
// -----------------------------------------------------------------------------
// caesar_stream_arbiter
// Shares one caesar_cipher core between two character streams. Bursts are
// granted round-robin; the granted stream's key/mode is latched for the whole
// burst, characters are tagged with their owner and results are routed back
// with that id.
//
// Parameters:
//   CORE_LAT  : core latency, ptxt_valid sampled -> ctx_ready (>= 1)
//   BURST_MAX : characters per grant before forced rearbitration (1..255)
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid/ready/char      : stream N character handshake
//   reqN_mode, reqN_key_*      : stream N mode and key (sampled at grant)
//   core_*  (out)              : registered plaintext and latched key to core
//   core_*  (in)               : core result, error flags, result strobe
//   rsp_valid/id/char/err_*    : result with owning stream id (no backpressure)
//   err_tag_mismatch           : sticky core/tag misalignment flag
// Optional feature macro: CAESAR_ARB_TAG_CHECK_EN enables the tag alignment
// check; when undefined err_tag_mismatch is tied 0.
// -----------------------------------------------------------------------------
module caesar_stream_arbiter
    import caesar_ctrl_pkg::*;
#(
    parameter int CORE_LAT  = 2,
    parameter int BURST_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_char,
    input  logic       req0_mode,
    input  logic       req0_key_dir_1,
    input  logic       req0_key_dir_3,
    input  logic [4:0] req0_key_num_1,
    input  logic [4:0] req0_key_num_3,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_char,
    input  logic       req1_mode,
    input  logic       req1_key_dir_1,
    input  logic       req1_key_dir_3,
    input  logic [4:0] req1_key_num_1,
    input  logic [4:0] req1_key_num_3,
    output logic       core_ptxt_valid,
    output logic       core_mode,
    output logic       core_key_shift_dir_1,
    output logic       core_key_shift_dir_3,
    output logic [4:0] core_key_shift_num_1,
    output logic [4:0] core_key_shift_num_3,
    output logic [7:0] core_ptxt_char,
    input  logic [7:0] core_ctxt_char,
    input  logic       core_err_key,
    input  logic       core_err_char,
    input  logic       core_ctx_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_char,
    output logic       rsp_err_key,
    output logic       rsp_err_char,
    output logic       err_tag_mismatch
);

    localparam int         DRAIN_W    = $clog2(CORE_LAT + 2);
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(CORE_LAT);

    state_e             state_q;
    logic               gnt_id_q;
    logic               rr_ptr_q;
    logic [7:0]         cnt_q;
    logic [DRAIN_W-1:0] drain_q;
    key_t               key_q;
    logic               ptxt_valid_q;
    logic [7:0]         ptxt_char_q;
    logic [CORE_LAT:0]  tag_vld_q, tag_vld_d;
    logic [CORE_LAT:0]  tag_id_q, tag_id_d;

    logic [1:0] req_valid;
    logic [1:0] gnt;
    logic       grant_id;
    key_t       key0, key1, grant_key;
    logic       sel_valid;
    logic [7:0] sel_char;
    logic       hs;

    assign req_valid = {req1_valid, req0_valid};
    assign key0 = {req0_mode, req0_key_dir_1, req0_key_dir_3, req0_key_num_1, req0_key_num_3};
    assign key1 = {req1_mode, req1_key_dir_1, req1_key_dir_3, req1_key_num_1, req1_key_num_3};

    caesar_rr_arb u_rr_arb (
        .valid_i  (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (gnt)
    );

    assign grant_id  = gnt[1] & ~gnt[0];
    assign grant_key = grant_id ? key1 : key0;

    // The granted stream is fixed for the burst, so select its lane by gnt_id_q.
    assign sel_valid = gnt_id_q ? req1_valid : req0_valid;
    assign sel_char  = gnt_id_q ? req1_char  : req0_char;
    assign hs        = (state_q == ISSUE) & sel_valid;

    assign req0_ready = (state_q == ISSUE) & ~gnt_id_q;
    assign req1_ready = (state_q == ISSUE) &  gnt_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_id_q     <= 1'b0;
            rr_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            drain_q      <= '0;
            key_q        <= '0;
            ptxt_valid_q <= 1'b0;
            ptxt_char_q  <= '0;
        end else begin
            ptxt_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        gnt_id_q <= grant_id;
                        key_q    <= grant_key;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sel_valid) begin
                        ptxt_char_q  <= sel_char;
                        ptxt_valid_q <= 1'b1;
                        cnt_q        <= cnt_q + 8'd1;
                        if (cnt_q == BURST_LAST) begin
                            state_q <= DRAIN;
                            drain_q <= '0;
                        end
                    end else begin
                        // An empty cycle ends the burst early.
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    // Key stays latched until the last in-flight char leaves the core.
                    if (drain_q == DRAIN_LAST) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= ~gnt_id_q;
                        cnt_q    <= '0;
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipe: entry 0 lines up with core_ptxt_valid, the tail with ctx_ready.
    always_comb begin
        tag_vld_d = {tag_vld_q[CORE_LAT-1:0], hs};
        tag_id_d  = {tag_id_q[CORE_LAT-1:0], hs & gnt_id_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign core_ptxt_valid      = ptxt_valid_q;
    assign core_ptxt_char       = ptxt_char_q;
    assign core_mode            = key_q.mode;
    assign core_key_shift_dir_1 = key_q.dir_1;
    assign core_key_shift_dir_3 = key_q.dir_3;
    assign core_key_shift_num_1 = key_q.num_1;
    assign core_key_shift_num_3 = key_q.num_3;

    // Result data is forwarded from the core, forced to zero outside a tagged slot.
    assign rsp_valid    = tag_vld_q[CORE_LAT];
    assign rsp_id       = tag_id_q[CORE_LAT];
    assign rsp_char     = rsp_valid ? core_ctxt_char : 8'h00;
    assign rsp_err_key  = rsp_valid & core_err_key;
    assign rsp_err_char = rsp_valid & core_err_char;

`ifdef CAESAR_ARB_TAG_CHECK_EN
    logic err_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_tag_q <= 1'b0;
        end else if (core_ctx_ready != tag_vld_q[CORE_LAT]) begin
            err_tag_q <= 1'b1;
        end
    end

    assign err_tag_mismatch = err_tag_q;

    a_tag_align: assert property (@(posedge clk) disable iff (!rst_n)
        core_ctx_ready == tag_vld_q[CORE_LAT]);
`else
    // Without the alignment check the core strobe has no consumer.
    logic unused_ctx_ready;
    assign unused_ctx_ready = core_ctx_ready;
    assign err_tag_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_caesar_stream_arbiter.sv
`timescale 1ns/1ps
module tb_caesar_stream_arbiter;
    import caesar_ctrl_pkg::*;

`ifdef CAESAR_ARB_TAG_CHECK_EN
    localparam int STUB_LAT = 3;
`else
    localparam int STUB_LAT = 2;
`endif
    localparam int LAT = 2;

    logic       clk, rst_n;
    logic       req0_valid, req0_ready, req0_mode, req0_key_dir_1, req0_key_dir_3;
    logic [7:0] req0_char;
    logic [4:0] req0_key_num_1, req0_key_num_3;
    logic       req1_valid, req1_ready, req1_mode, req1_key_dir_1, req1_key_dir_3;
    logic [7:0] req1_char;
    logic [4:0] req1_key_num_1, req1_key_num_3;
    logic       core_ptxt_valid, core_mode, core_key_shift_dir_1, core_key_shift_dir_3;
    logic [4:0] core_key_shift_num_1, core_key_shift_num_3;
    logic [7:0] core_ptxt_char, core_ctxt_char;
    logic       core_err_key, core_err_char, core_ctx_ready;
    logic       rsp_valid, rsp_id, rsp_err_key, rsp_err_char, err_tag_mismatch;
    logic [7:0] rsp_char;
    logic [36:0] outs;

    typedef struct packed {
        logic       id;
        logic [7:0] ch;
        logic       ek;
        logic       ec;
        int         due;
    } exp_t;

    exp_t        sbq[$];
    key_t        key0_exp, key1_exp;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        hs0, hs1, got, late;
    logic [10:0] act, expv;
    int          due;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    caesar_stream_arbiter #(.CORE_LAT(LAT), .BURST_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_char(req0_char),
        .req0_mode(req0_mode), .req0_key_dir_1(req0_key_dir_1), .req0_key_dir_3(req0_key_dir_3),
        .req0_key_num_1(req0_key_num_1), .req0_key_num_3(req0_key_num_3),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_char(req1_char),
        .req1_mode(req1_mode), .req1_key_dir_1(req1_key_dir_1), .req1_key_dir_3(req1_key_dir_3),
        .req1_key_num_1(req1_key_num_1), .req1_key_num_3(req1_key_num_3),
        .core_ptxt_valid(core_ptxt_valid), .core_mode(core_mode),
        .core_key_shift_dir_1(core_key_shift_dir_1), .core_key_shift_dir_3(core_key_shift_dir_3),
        .core_key_shift_num_1(core_key_shift_num_1), .core_key_shift_num_3(core_key_shift_num_3),
        .core_ptxt_char(core_ptxt_char), .core_ctxt_char(core_ctxt_char),
        .core_err_key(core_err_key), .core_err_char(core_err_char), .core_ctx_ready(core_ctx_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_char(rsp_char),
        .rsp_err_key(rsp_err_key), .rsp_err_char(rsp_err_char),
        .err_tag_mismatch(err_tag_mismatch)
    );

    assign outs = {req0_ready, req1_ready, core_ptxt_valid, core_mode, core_key_shift_dir_1,
                   core_key_shift_dir_3, core_key_shift_num_1, core_key_shift_num_3, core_ptxt_char,
                   rsp_valid, rsp_id, rsp_char, rsp_err_key, rsp_err_char, err_tag_mismatch};

    // Reference Caesar model: dir 0 shifts forward, dir 1 backward; encrypt
    // applies shift 1 then shift 3, decrypt undoes them in reverse order.
    function automatic logic is_letter(logic [7:0] c);
        return (c >= UPPERCASE_A && c <= UPPERCASE_Z) || (c >= LOWERCASE_A && c <= LOWERCASE_Z);
    endfunction

    function automatic logic key_bad(key_t k);
        return (int'(k.num_1) > KEY_NUM_MAX) || (int'(k.num_3) > KEY_NUM_MAX) || (k.num_1 == k.num_3);
    endfunction

    function automatic logic [7:0] shl(logic [7:0] c, logic dir, logic [4:0] n);
        int base, off, s;
        if (c >= UPPERCASE_A && c <= UPPERCASE_Z)      base = int'(UPPERCASE_A);
        else if (c >= LOWERCASE_A && c <= LOWERCASE_Z) base = int'(LOWERCASE_A);
        else return c;
        s   = int'(n) % 26;
        off = int'(c) - base;
        off = dir ? (off - s + 26) % 26 : (off + s) % 26;
        return 8'(base + off);
    endfunction

    function automatic logic [7:0] cipher(key_t k, logic [7:0] c);
        if (!k.mode) return shl(shl(c, k.dir_1, k.num_1), k.dir_3, k.num_3);
        return shl(shl(c, !k.dir_3, k.num_3), !k.dir_1, k.num_1);
    endfunction

    function automatic exp_t mk(logic id, key_t k, logic [7:0] c, int d);
        exp_t e;
        e.id = id; e.ch = cipher(k, c); e.ek = key_bad(k); e.ec = !is_letter(c); e.due = d;
        return e;
    endfunction

    // Stub core with STUB_LAT cycles of latency, driven from the DUT's core outputs.
    logic [STUB_LAT:1] st_v;
    logic [9:0]        st_d [1:STUB_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v <= '0;
            for (int i = 1; i <= STUB_LAT; i++) st_d[i] <= '0;
        end else begin
            st_v    <= {st_v[STUB_LAT-1:1], core_ptxt_valid};
            st_d[1] <= {key_bad({core_mode, core_key_shift_dir_1, core_key_shift_dir_3,
                                 core_key_shift_num_1, core_key_shift_num_3}),
                        !is_letter(core_ptxt_char),
                        cipher({core_mode, core_key_shift_dir_1, core_key_shift_dir_3,
                                core_key_shift_num_1, core_key_shift_num_3}, core_ptxt_char)};
            for (int i = 2; i <= STUB_LAT; i++) st_d[i] <= st_d[i-1];
        end
    end
    assign core_ctx_ready = st_v[STUB_LAT];
    assign {core_err_key, core_err_char, core_ctxt_char} = st_d[STUB_LAT];

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // One cycle: sample at negedge, record handshakes with their due cycle,
    // pair any response with the oldest expectation, then step past posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        hs0 = req0_valid & req0_ready;
        hs1 = req1_valid & req1_ready;
        if (hs0) sbq.push_back(mk(1'b0, key0_exp, req0_char, cyc + LAT + 1));
        if (hs1) sbq.push_back(mk(1'b1, key1_exp, req1_char, cyc + LAT + 1));
        got  = rsp_valid;
        act  = {rsp_id, rsp_char, rsp_err_key, rsp_err_char};
        expv = 'x;
        due  = -1;
        if (got && sbq.size() > 0) begin
            e = sbq.pop_front();
            expv = {e.id, e.ch, e.ek, e.ec};
            due  = e.due;
        end
        late = (sbq.size() > 0) && (sbq[0].due < cyc);
        if (late) void'(sbq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req0_valid = 0; req0_char = 0; req1_valid = 0; req1_char = 0;
        {req0_mode, req0_key_dir_1, req0_key_dir_3, req0_key_num_1, req0_key_num_3} = '0;
        {req1_mode, req1_key_dir_1, req1_key_dir_3, req1_key_num_1, req1_key_num_3} = '0;
        rst_n = 1'b0;
        #3;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL idle_outputs got=%h exp=0", outs); end
    endtask

    task automatic test_single();
        int idx = 0, guard = 0, nrsp = 0;
        int hc[26];
        key0_exp = '{1'b0, 1'b1, 1'b0, 5'd25, 5'd5};
        {req0_mode, req0_key_dir_1, req0_key_dir_3, req0_key_num_1, req0_key_num_3} = key0_exp;
        while ((idx < 26 || sbq.size() > 0) && guard < 300) begin
            req0_valid = (idx < 26);
            req0_char  = 8'(8'h41 + idx);
            tick();
            guard++;
            if (hs0) begin hc[idx] = cyc; idx++; end
            if (got) begin
                nrsp++;
                checks++;
                if (act !== expv) begin errors++; $display("FAIL single_rsp got=%h exp=%h", act, expv); end
                checks++;
                if (cyc !== due) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", cyc, due); end
            end
            if (late) begin checks++; errors++; $display("FAIL single_missing_rsp cycle=%0d", cyc); end
        end
        req0_valid = 1'b0;
        checks++;
        if (nrsp !== 26) begin errors++; $display("FAIL single_count got=%0d exp=26", nrsp); end
        checks++;
        if (hc[15] - hc[0] !== 15) begin errors++; $display("FAIL single_burst1_span got=%0d exp=15", hc[15] - hc[0]); end
        checks++;
        if (hc[16] - hc[15] !== 5) begin errors++; $display("FAIL single_switch_gap got=%0d exp=5", hc[16] - hc[15]); end
        checks++;
        if (hc[25] - hc[16] !== 9) begin errors++; $display("FAIL single_burst2_span got=%0d exp=9", hc[25] - hc[16]); end
    endtask

    task automatic test_both();
        int i0 = 0, i1 = 0, guard = 0, nrsp = 0, n1 = 0;
        logic exp_id;
        do_reset();
        key0_exp = '{1'b0, 1'b0, 1'b0, 5'd25, 5'd26};
        key1_exp = '{1'b1, 1'b0, 1'b0, 5'd25, 5'd26};
        {req0_mode, req0_key_dir_1, req0_key_dir_3, req0_key_num_1, req0_key_num_3} = key0_exp;
        {req1_mode, req1_key_dir_1, req1_key_dir_3, req1_key_num_1, req1_key_num_3} = key1_exp;
        while ((i0 < 32 || i1 < 16 || sbq.size() > 0) && guard < 400) begin
            req0_valid = (i0 < 32);
            req0_char  = 8'(8'h41 + i0 % 26);
            req1_valid = (i1 < 16);
            req1_char  = cipher(key0_exp, 8'(8'h41 + i1 % 26));
            tick();
            guard++;
            if (hs0) i0++;
            if (hs1) i1++;
            if (got) begin
                checks++;
                if (act !== expv) begin errors++; $display("FAIL both_rsp got=%h exp=%h", act, expv); end
                checks++;
                if (cyc !== due) begin errors++; $display("FAIL both_latency got=%0d exp=%0d", cyc, due); end
                exp_id = 1'((nrsp / 16) % 2);
                checks++;
                if (act[10] !== exp_id) begin errors++; $display("FAIL both_burst_order rsp=%0d got=%b exp=%b", nrsp, act[10], exp_id); end
                if (act[10]) begin
                    checks++;
                    if (act[9:2] !== 8'(8'h41 + n1 % 26)) begin
                        errors++; $display("FAIL both_roundtrip got=%h exp=%h", act[9:2], 8'(8'h41 + n1 % 26));
                    end
                    n1++;
                end
                nrsp++;
            end
            if (late) begin checks++; errors++; $display("FAIL both_missing_rsp cycle=%0d", cyc); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (nrsp !== 48) begin errors++; $display("FAIL both_count got=%0d exp=48", nrsp); end
    endtask

    task automatic test_key_change();
        int i = 0, guard = 0, nrsp = 0;
        key0_exp = '{1'b0, 1'b0, 1'b1, 5'd16, 5'd4};
        {req0_mode, req0_key_dir_1, req0_key_dir_3, req0_key_num_1, req0_key_num_3} = key0_exp;
        while ((i < 16 || sbq.size() > 0) && guard < 200) begin
            req0_valid     = (i < 16);
            req0_char      = 8'(8'h61 + i);
            req0_key_num_1 = (i >= 5) ? 5'd3 : 5'd16;
            tick();
            guard++;
            if (hs0) i++;
            if (got) begin
                nrsp++;
                checks++;
                if (act !== expv) begin errors++; $display("FAIL keychg_rsp got=%h exp=%h", act, expv); end
                checks++;
                if (cyc !== due) begin errors++; $display("FAIL keychg_latency got=%0d exp=%0d", cyc, due); end
            end
            if (late) begin checks++; errors++; $display("FAIL keychg_missing_rsp cycle=%0d", cyc); end
        end
        req0_valid = 1'b0;
        checks++;
        if (core_key_shift_num_1 !== 5'd16) begin errors++; $display("FAIL keychg_latched got=%0d exp=16", core_key_shift_num_1); end
        checks++;
        if (nrsp !== 16) begin errors++; $display("FAIL keychg_count got=%0d exp=16", nrsp); end
        req0_key_num_1 = 5'd16;
    endtask

    task automatic test_invalid();
        int i = 0, guard = 0, nrsp = 0;
        logic exp_ec;
        key0_exp = '{1'b0, 1'b0, 1'b0, 5'd28, 5'd1};
        {req0_mode, req0_key_dir_1, req0_key_dir_3, req0_key_num_1, req0_key_num_3} = key0_exp;
        while ((i < 128 || sbq.size() > 0) && guard < 1000) begin
            req0_valid = (i < 128);
            req0_char  = 8'(i);
            tick();
            guard++;
            if (hs0) i++;
            if (got) begin
                checks++;
                if (act !== expv) begin errors++; $display("FAIL inv_rsp got=%h exp=%h", act, expv); end
                checks++;
                if (act[1] !== 1'b1) begin errors++; $display("FAIL inv_err_key char=%0d got=%b exp=1", nrsp, act[1]); end
                exp_ec = !((nrsp >= 65 && nrsp <= 90) || (nrsp >= 97 && nrsp <= 122));
                checks++;
                if (act[0] !== exp_ec) begin errors++; $display("FAIL inv_err_char char=%0d got=%b exp=%b", nrsp, act[0], exp_ec); end
                nrsp++;
            end
            if (late) begin checks++; errors++; $display("FAIL inv_missing_rsp cycle=%0d", cyc); end
        end
        req0_valid = 1'b0;
        checks++;
        if (nrsp !== 128) begin errors++; $display("FAIL inv_count got=%0d exp=128", nrsp); end
    endtask

    task automatic test_reset_mid();
        int i = 0, guard = 0;
        logic seen_hs = 1'b0;
        key0_exp = '{1'b0, 1'b0, 1'b0, 5'd3, 5'd7};
        key1_exp = key0_exp;
        {req0_mode, req0_key_dir_1, req0_key_dir_3, req0_key_num_1, req0_key_num_3} = key0_exp;
        {req1_mode, req1_key_dir_1, req1_key_dir_3, req1_key_num_1, req1_key_num_3} = key1_exp;
        while (i < 3 && guard < 100) begin
            req1_valid = 1'b1;
            req1_char  = 8'(8'h4B + i);
            tick();
            guard++;
            if (hs1) i++;
        end
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midreset_outputs got=%h exp=0", outs); end
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req0_valid = 1'b1; req0_char = 8'h51;
        req1_valid = 1'b1; req1_char = 8'h52;
        guard = 0;
        while (!seen_hs && guard < 20) begin
            tick();
            guard++;
            if (got) begin checks++; errors++; $display("FAIL midreset_spurious_rsp cycle=%0d", cyc); end
            if (hs0 || hs1) begin
                seen_hs = 1'b1;
                checks++;
                if ({hs0, hs1} !== 2'b10) begin errors++; $display("FAIL midreset_next_grant got=%b exp=10", {hs0, hs1}); end
            end
        end
        checks++;
        if (!seen_hs) begin errors++; $display("FAIL midreset_no_grant got=0 exp=1"); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) begin
            tick();
            if (got) begin
                checks++;
                if (act !== expv) begin errors++; $display("FAIL midreset_rsp got=%h exp=%h", act, expv); end
            end
            if (late) begin checks++; errors++; $display("FAIL midreset_missing_rsp cycle=%0d", cyc); end
        end
        checks++;
        if (err_tag_mismatch !== 1'b0) begin errors++; $display("FAIL tag_flag_default got=%b exp=0", err_tag_mismatch); end
    endtask

`ifdef CAESAR_ARB_TAG_CHECK_EN
    task automatic test_tag_check();
        int guard = 0;
        do_reset();
        key0_exp = '{1'b0, 1'b0, 1'b0, 5'd3, 5'd7};
        {req0_mode, req0_key_dir_1, req0_key_dir_3, req0_key_num_1, req0_key_num_3} = key0_exp;
        req0_valid = 1'b1; req0_char = 8'h41;
        hs0 = 1'b0;
        while (!hs0 && guard < 20) begin tick(); guard++; end
        req0_valid = 1'b0;
        repeat (LAT + 2) tick();
        checks++;
        if (err_tag_mismatch !== 1'b1) begin errors++; $display("FAIL tag_flag_set got=%b exp=1", err_tag_mismatch); end
        repeat (6) tick();
        checks++;
        if (err_tag_mismatch !== 1'b1) begin errors++; $display("FAIL tag_flag_sticky got=%b exp=1", err_tag_mismatch); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CAESAR_ARB_TAG_CHECK_EN
        test_tag_check();
`else
        test_single();
        test_both();
        test_key_change();
        test_invalid();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/caesar_stream_arbiter.md
Name: caesar_stream_arbiter

Overview:
- Two-requester scheduler that shares one `caesar_cipher` core between independent character streams (e.g. an encrypt channel and a decrypt channel).
- Each stream presents its own mode and key. The block grants bursts round-robin, latches the granted stream's key/mode for the whole burst, drives the core, tags in-flight characters and routes the core results back with the owning stream id.
- Sits directly in front of the core; the core is instantiated beside it at the next level up.

Parameters:
- CORE_LAT, 2: core latency in cycles, from `ptxt_valid` sampled to `ctx_ready`/`ctxt_char` valid.
- BURST_MAX, 16: maximum characters issued per grant before forced rearbitration (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  stream N (N=0,1) has a character
- reqN_ready  out  1  character accepted this cycle
- reqN_char  in  8  ASCII character
- reqN_mode  in  1  0 = encrypt, 1 = decrypt
- reqN_key_dir_1, reqN_key_dir_3  in  1  shift directions
- reqN_key_num_1, reqN_key_num_3  in  5  shift amounts
- core_ptxt_valid, core_mode, core_key_shift_dir_1, core_key_shift_dir_3  out  1  to core
- core_key_shift_num_1, core_key_shift_num_3  out  5  to core
- core_ptxt_char  out  8  to core
- core_ctxt_char  in  8  from core
- core_err_key, core_err_char, core_ctx_ready  in  1  from core
- rsp_valid  out  1  result available (no backpressure; sink always accepts)
- rsp_id  out  1  owning stream
- rsp_char  out  8  core result
- rsp_err_key, rsp_err_char  out  1  core error flags for this result
- err_tag_mismatch  out  1  sticky; see Optional Feature

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, burst count=0, tag pipe cleared.
  - All outputs 0, including `core_ptxt_char` and the core key outputs.
  - Reset mid-burst discards in-flight characters; no response is produced for them.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any reqN_valid is high, grant by round-robin. rr_ptr marks the preferred stream; the other stream wins only when the preferred one is idle.
  - Latch the granted stream's mode, dirs and nums into the key register; go to ISSUE.
  - `reqN_ready` is 0 in IDLE.
- ISSUE:
  - `reqG_ready`=1 for the granted stream only; the other stream's ready is 0.
  - On valid&ready: register the char into `core_ptxt_char`, set `core_ptxt_valid`=1 next cycle, push tag {1,G}, increment count.
  - Key/mode changes on the requester during a burst are ignored; the latched values drive the core.
  - Leave to DRAIN when the count reaches BURST_MAX on a handshake, or when reqG_valid=0 while ready=1. An empty cycle ends the burst.
- DRAIN:
  - Hold the key outputs stable and `core_ptxt_valid`=0 for CORE_LAT+1 cycles, so in-flight characters complete with their key.
  - Then go to IDLE with rr_ptr = ~G and count=0.
  - Simultaneous valid on both streams therefore alternates bursts: 0,1,0,...
- Latency:
  - Request handshake at cycle t → `core_ptxt_valid` at t+1 → rsp_valid at t+1+CORE_LAT.
  - With CORE_LAT=2 that is t+3.
- Response path:
  - Tag shift register of depth CORE_LAT+1; rsp_valid/rsp_id come from the tail.
  - rsp_char and both error flags pass through combinationally from the core.
- Invalid key (num>26 or num_1==num_3) or invalid char: still issued; the core's error flags are forwarded unchanged in rsp_err_*.
- Throughput: 1 char/cycle inside a burst; switch overhead is CORE_LAT+2 cycles (1 IDLE + CORE_LAT+1 DRAIN).

Optional Feature:
- Macro CAESAR_ARB_TAG_CHECK_EN.
- When defined: every cycle compare core_ctx_ready against the tag tail valid. On any difference set err_tag_mismatch; it stays set until reset. A simulation assertion also fires.
- When undefined: err_tag_mismatch is tied 0 and there is no compare logic.

Decomposition:
- Package caesar_ctrl_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN};
  - key_t struct {mode, dir_1, dir_3, num_1[4:0], num_3[4:0]};
  - constants UPPERCASE_A/Z, LOWERCASE_A/Z and KEY_NUM_MAX=26.
- One sub-module: caesar_rr_arb, the 2-way round-robin grant taking valid[1:0] and rr_ptr, returning a one-hot grant.

Test Plan:
- Single stream: req0 sends "A".."Z", mode=0, key {1,25,0,5}, valid held for 26 cycles → two bursts (16+10) each followed by a drain. rsp_id=0 and rsp_char matches the C model for all 26 chars, each at handshake+3.
- Both streams valid continuously: req0 encrypts, req1 decrypts with key {0,25,0,26} → bursts alternate 0,1,0 of 16 chars each. No response carries the wrong id, and req0's ciphertext passed through req1 recovers the plaintext.
- Mid-burst key change: req0 flips key_num_1 from 16 to 3 at char 5 → all 16 chars of the burst are encrypted with 16.
- Invalid key {0,28,0,1} and a char sweep 0x00..0x7F → rsp_err_key=1 on every response; rsp_err_char=1 exactly for non-letters; 128 responses in order.
- Reset asserted 1 cycle after 3 handshakes → all outputs 0 immediately; no rsp_valid for those chars after release; the next grant goes to stream 0.
- With CAESAR_ARB_TAG_CHECK_EN defined and a stub core using CORE_LAT=3 against parameter 2 → err_tag_mismatch=1 on the first response and stays set.
